alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides and a
// result accumulator that can stand in for operand a.
//   S1: operand register; the ALU result is computed from it combinationally.
//   S2: result/flag register that drives y, the flags and out_valid.
module alu_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             acc_sel,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    // S1 operand stage
    logic             s1_full_q;
    logic             s1_full_d;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    op_e              s1_op_q;
    logic             s1_acc_sel_q;

    // S2 result stage
    logic             s2_full_q;
    logic             s2_full_d;
    logic [WIDTH-1:0] y_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;

    // Accumulator
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // Handshake / pipeline control
    logic             s1_adv_c;
    logic             in_ready_c;
    logic             in_fire_c;

    // ALU datapath
    logic [WIDTH-1:0] op_a_c;
    logic [WIDTH-1:0] op_b_c;
    logic [WIDTH:0]   sum_ext_c;
    logic [WIDTH:0]   dif_ext_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             zero_c;
    logic             neg_c;

    // ALU: operand a is swapped for the accumulator when the op asked for it
    always_comb begin
        op_a_c    = s1_acc_sel_q ? acc_q : s1_a_q;
        op_b_c    = s1_b_q;
        sum_ext_c = {1'b0, op_a_c} + {1'b0, op_b_c};
        dif_ext_c = {1'b0, op_a_c} - {1'b0, op_b_c};
        res_c     = '0;
        carry_c   = 1'b0;
        ovf_c     = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_c   = sum_ext_c[MSB:0];
                carry_c = sum_ext_c[WIDTH];
            end
            OP_SUB: begin
                res_c   = dif_ext_c[MSB:0];
                // Wrap into the extra bit means a < b unsigned: the borrow.
                carry_c = dif_ext_c[WIDTH];
            end
            OP_AND: res_c = op_a_c & op_b_c;
            OP_OR:  res_c = op_a_c | op_b_c;
            OP_XOR: res_c = op_a_c ^ op_b_c;
            OP_NOT: res_c = ~op_a_c;
            OP_SHL: begin
                res_c   = {op_a_c[MSB-1:0], 1'b0};
                carry_c = op_a_c[MSB];
            end
            OP_SHR: begin
                res_c   = {1'b0, op_a_c[MSB:1]};
                carry_c = op_a_c[0];
            end
            default: begin
                res_c   = '0;
                carry_c = 1'b0;
            end
        endcase
        // Signed overflow: add of like signs, or sub of unlike signs, that flips sign.
        if (s1_op_q == OP_ADD) begin
            ovf_c = (op_a_c[MSB] == op_b_c[MSB]) && (res_c[MSB] != op_a_c[MSB]);
        end else if (s1_op_q == OP_SUB) begin
            ovf_c = (op_a_c[MSB] != op_b_c[MSB]) && (res_c[MSB] != op_a_c[MSB]);
        end
        zero_c = (res_c == '0);
        neg_c  = res_c[MSB];
    end

    // Pipeline control and next-state for occupancy and accumulator
    always_comb begin
        s1_adv_c   = s1_full_q && (!s2_full_q || out_ready);
        in_ready_c = !rst && (!s1_full_q || s1_adv_c);
        in_fire_c  = in_valid && in_ready_c;

        s1_full_d = s1_full_q;
        if (in_fire_c) begin
            s1_full_d = 1'b1;
        end else if (s1_adv_c) begin
            s1_full_d = 1'b0;
        end

        s2_full_d = s2_full_q;
        if (s1_adv_c) begin
            s2_full_d = 1'b1;
        end else if (out_ready) begin
            s2_full_d = 1'b0;
        end

        // Clear wins over the advance update; the advancing result still reaches S2.
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (s1_adv_c) begin
            acc_d = res_c;
        end
    end

    // S1 register: capture operands on an accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_full_q    <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_ADD;
            s1_acc_sel_q <= 1'b0;
        end else begin
            s1_full_q <= s1_full_d;
            if (in_fire_c) begin
                s1_a_q       <= a;
                s1_b_q       <= b;
                s1_op_q      <= op_e'(sel);
                s1_acc_sel_q <= acc_sel;
            end
        end
    end

    // S2 register: load result and flags on advance, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_full_q <= 1'b0;
            y_q       <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s2_full_q <= s2_full_d;
            if (s1_adv_c) begin
                y_q     <= res_c;
                carry_q <= carry_c;
                zero_q  <= zero_c;
                neg_q   <= neg_c;
                ovf_q   <= ovf_c;
            end
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign y         = y_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign out_valid = s2_full_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=4): directed vectors with literal expectations
// plus an in-order reference queue checked every cycle on the falling edge.
module tb_alu_pipe;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         z;
        logic         n;
        logic         o;
    } res_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         acc_sel;
    logic         acc_clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    res_t exp_q[$];
    int   acc_m;
    bit   stall_p;
    res_t held_p;

    alu_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .acc_sel  (acc_sel),
        .acc_clr  (acc_clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .carry    (carry),
        .zero     (zero),
        .neg      (neg),
        .ovf      (ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference ALU from the opcode table, plain integer arithmetic
    function automatic res_t model(input int ua, input int ub, input int op);
        int   r;
        int   s;
        int   sa;
        int   sb;
        res_t t;
        t  = '0;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        r  = 0;
        case (op)
            0: begin r = ua + ub; t.c = (r > 15); s = sa + sb; t.o = (s > 7) || (s < -8); end
            1: begin r = ua - ub; t.c = (ua < ub); s = sa - sb; t.o = (s > 7) || (s < -8); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = 15 - ua;
            6: begin r = ua * 2; t.c = (ua >= 8); end
            default: begin r = ua / 2; t.c = (ua % 2) == 1; end
        endcase
        r   = ((r % 16) + 16) % 16;
        t.y = 4'(r);
        t.z = (r == 0);
        t.n = (r >= 8);
        return t;
    endfunction

    // Falling-edge monitor: reference queue, ordering and hold checks
    always @(negedge clk) begin
        res_t e;
        res_t m;
        if (rst) begin
            exp_q.delete();
            acc_m   = 0;
            stall_p = 1'b0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_y", int'(y), 0);
        end else begin
            if (stall_p) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_result", int'({y, carry, zero, neg, ovf}), int'(held_p));
            end
            if (exp_q.size() == 0) begin
                chk("no_spurious_out", int'(out_valid), 0);
            end else if (out_valid) begin
                e = exp_q[0];
                chk("mon_y", int'(y), int'(e.y));
                chk("mon_flags", int'({carry, zero, neg, ovf}), int'({e.c, e.z, e.n, e.o}));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
            if (acc_clr) begin
                acc_m = 0;
            end
            if (in_valid && in_ready) begin
                m = model(acc_sel ? acc_m : int'(a), int'(b), int'(sel));
                exp_q.push_back(m);
                acc_m = int'(m.y);
            end
            stall_p = out_valid && !out_ready;
            held_p  = {y, carry, zero, neg, ovf};
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one op for up to maxw cycles; got=1 if it transferred
    task automatic try_send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic [2:0] ts, input logic tacc,
                            input int maxw, output bit got);
        a        = ta;
        b        = tb_v;
        sel      = ts;
        acc_sel  = tacc;
        in_valid = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < maxw && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [2:0] ts, input logic tacc);
        bit got;
        try_send(ta, tb_v, ts, tacc, 8, got);
        chk("accept_timeout", int'(got), 1);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] ey,
                              input logic ec, input logic ez, input logic en, input logic eo);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_y"}, int'(y), int'(ey));
        chk({name, "_carry"}, int'(carry), int'(ec));
        chk({name, "_zero"}, int'(zero), int'(ez));
        chk({name, "_neg"}, int'(neg), int'(en));
        chk({name, "_ovf"}, int'(ovf), int'(eo));
    endtask

    task automatic set_op(input int i);
        a       = 4'((i * 7 + 3) % 16);
        b       = 4'((i * 5 + 1) % 16);
        sel     = 3'(i % 8);
        acc_sel = (i % 3) == 0;
    endtask

    // Stream n ops back to back, optionally with a fixed backpressure pattern
    task automatic stream(input int n, input bit bp, output int cycles);
        int idx;
        bit acc_now;
        idx    = 0;
        cycles = 0;
        set_op(0);
        in_valid = 1'b1;
        while (idx < n && cycles < 400) begin
            out_ready = bp ? (((cycles % 4) != 2) && ((cycles % 7) != 5)) : 1'b1;
            @(negedge clk);
            acc_now = in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (acc_now) begin
                idx++;
                if (idx < n) set_op(idx);
            end
        end
        in_valid  = 1'b0;
        acc_sel   = 1'b0;
        out_ready = 1'b1;
        chk("stream_ops_accepted", idx, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   got;
        int   n_acc;
        int   cyc;
        logic [W-1:0] y_hold;

        rst = 1'b1; a = '0; b = '0; sel = '0; acc_sel = 1'b0; acc_clr = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_flags", int'({carry, zero, neg, ovf}), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("release_in_ready", int'(in_ready), 1);

        // Add with carry and signed overflow
        send(4'b1100, 4'b1010, 3'b000, 1'b0);
        expect_out("add", 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1);

        // Sub with borrow/overflow, then both shifts
        send(4'b0100, 4'b1010, 3'b001, 1'b0);
        expect_out("sub", 4'b1010, 1'b1, 1'b0, 1'b1, 1'b1);
        send(4'b1010, 4'b0000, 3'b110, 1'b0);
        expect_out("shl", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        send(4'b1010, 4'b0000, 3'b111, 1'b0);
        expect_out("shr", 4'b0101, 1'b0, 1'b0, 1'b1 & 1'b0, 1'b0);

        // XOR to zero
        send(4'b0101, 4'b0101, 3'b100, 1'b0);
        expect_out("xor", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clear the accumulator, then chain three accumulate adds
        acc_clr = 1'b1;
        idle(1);
        acc_clr = 1'b0;
        a = 4'b1111; b = 4'b0011; sel = 3'b000; acc_sel = 1'b1; in_valid = 1'b1;
        idle(1);
        idle(1);
        chk("chain0_y", int'(y), 3);
        chk("chain0_valid", int'(out_valid), 1);
        chk("chain_in_ready", int'(in_ready), 1);
        idle(1);
        in_valid = 1'b0; acc_sel = 1'b0;
        chk("chain1_y", int'(y), 6);
        idle(1);
        chk("chain2_y", int'(y), 9);
        chk("chain2_neg", int'(neg), 1);
        chk("chain2_ovf", int'(ovf), 1);
        idle(2);

        // Backpressure: only two ops fit while the output is blocked
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 1; i <= 4; i++) begin
            try_send(4'(i), 4'b0001, 3'b000, 1'b0, 3, got);
            if (got) n_acc++;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_in_ready", int'(in_ready), 0);
        y_hold = y;
        chk("bp_head_y", int'(y), 2);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("bp_y_stable", int'(y), int'(y_hold));
            chk("bp_valid_stable", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(4'd3, 4'b0001, 3'b000, 1'b0);
        chk("bp_second_y", int'(y), 3);
        send(4'd4, 4'b0001, 3'b000, 1'b0);
        idle(3);
        chk("bp_drained", exp_q.size(), 0);

        // Full throughput, then a throttled stream
        stream(12, 1'b0, cyc);
        chk("full_throughput_cycles", cyc, 12);
        idle(3);
        stream(16, 1'b1, cyc);
        idle(4);
        chk("stream_drained", exp_q.size(), 0);

        // Reset mid-cycle with both stages full
        out_ready = 1'b0;
        send(4'b0011, 4'b0100, 3'b000, 1'b0);
        send(4'b0110, 4'b0001, 3'b001, 1'b0);
        chk("full_before_rst", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("no_stale_out", int'(out_valid), 0);
        end
        send(4'b1111, 4'b0000, 3'b011, 1'b1);
        expect_out("acc_after_rst", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
